bf16_add_sched: RTL

- Shares one combinational bf16_add datapath between N_REQ requesters.
- Each requester has a valid/ready handshake.
- Round-robin arbitration selects one request per cycle. The block registers its operands, runs them through bf16_add and registers the sum, so up to two operations are in flight.
- Results return on a single output channel with backpressure, tagged with the requester ID.

---
 rtl/bf16_pkg.sv | 15 +
 rtl/bf16_add_sched_if.sv | 38 +++
 rtl/bf16_add.sv | 105 ++++++++++
 rtl/bf16_rr_arb.sv | 37 +++
 rtl/bf16_add_sched.sv | 110 +++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared bf16 definitions: the packed {sign, exponent, mantissa} view and a few
// constants used by the adder, the scheduler and anything that talks to them.
package bf16_pkg;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
  } bf16_t;

  localparam logic [15:0] BF16_POS_ZERO = 16'h0000;
  localparam logic [15:0] BF16_ONE      = 16'h3F80;
  localparam logic [15:0] BF16_QNAN     = 16'h7FC0;

endpackage

// File: rtl/bf16_add_sched_if.sv
// Request/result bundle of the shared bf16 adder scheduler. The scheduler uses
// the slave view; requesters and the result consumer together use the master view.
// Optional macro BF16_ADD_SCHED_STATS_EN adds the per-requester grant counters.
interface bf16_add_sched_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic [N_REQ-1:0]    req_sub_i;
  logic [N_REQ*16-1:0] req_a_i;
  logic [N_REQ*16-1:0] req_b_i;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [ID_W-1:0]     res_id_o;
  logic [15:0]         res_o;
`ifdef BF16_ADD_SCHED_STATS_EN
  logic [N_REQ*16-1:0] grant_cnt_o;
`endif

  modport slave (
    input  req_valid_i, req_sub_i, req_a_i, req_b_i, res_ready_i,
    output req_ready_o, res_valid_o, res_id_o, res_o
`ifdef BF16_ADD_SCHED_STATS_EN
    , output grant_cnt_o
`endif
  );

  modport master (
    output req_valid_i, req_sub_i, req_a_i, req_b_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_id_o, res_o
`ifdef BF16_ADD_SCHED_STATS_EN
    , input grant_cnt_o
`endif
  );

endinterface

// File: rtl/bf16_add.sv
// Combinational bf16 adder, round-to-nearest-even. Subnormal inputs are treated
// as zero and results that underflow flush to a signed zero. NaN in or inf-inf
// gives the canonical quiet NaN; overflow gives a signed infinity.
module bf16_add
  import bf16_pkg::*;
(
  input  bf16_t a,
  input  bf16_t b,
  output bf16_t y
);

  bf16_t              big, sml;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0]         d;
  logic [18:0]        sml_full;
  logic [10:0]        big_sig, sml_sig, norm;
  logic [11:0]        sum;
  logic signed [9:0]  exp_n;
  logic [3:0]         lz;
  logic               found;
  logic               round_up;
  logic [7:0]         mant_r;

  // Align, add or subtract, normalise, round, then pick special-case results.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    y        = bf16_t'(BF16_POS_ZERO);
    found    = 1'b0;
    lz       = '0;
    sum      = '0;
    norm     = '0;

    a_nan  = (a.e == 8'hFF) && (a.m != 7'd0);
    b_nan  = (b.e == 8'hFF) && (b.m != 7'd0);
    a_inf  = (a.e == 8'hFF) && (a.m == 7'd0);
    b_inf  = (b.e == 8'hFF) && (b.m == 7'd0);
    a_zero = (a.e == 8'h00);
    b_zero = (b.e == 8'h00);

    // Larger magnitude goes first so the difference is never negative.
    if ({a.e, a.m} >= {b.e, b.m}) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end

    // Significands carry hidden bit, 7 fraction bits, guard, round and sticky.
    d        = big.e - sml.e;
    big_sig  = {1'b1, big.m, 3'b000};
    sml_full = {1'b1, sml.m, 3'b000, 8'h00} >> d;
    sml_sig  = sml_full[18:8] | {10'd0, |sml_full[7:0]};
    exp_n    = {2'b00, big.e};

    if (big.s == sml.s) begin
      sum = {1'b0, big_sig} + {1'b0, sml_sig};
      if (sum[11]) begin
        norm  = sum[11:1] | {10'd0, sum[0]};
        exp_n = exp_n + 10'sd1;
      end else begin
        norm = sum[10:0];
      end
    end else begin
      norm = big_sig - sml_sig;
      for (int i = 10; i >= 0; i--) begin
        if (!found && norm[i]) begin
          found = 1'b1;
          lz    = 4'(10 - i);
        end
      end
      norm  = norm << lz;
      exp_n = exp_n - signed'({6'd0, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[9:3]} + {7'd0, round_up};
    if (mant_r[7]) begin
      exp_n = exp_n + 10'sd1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a.s != b.s))) begin
      y = bf16_t'(BF16_QNAN);
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (a_zero && b_zero) begin
      y = {a.s & b.s, 15'd0};
    end else if (a_zero) begin
      y = b;
    end else if (b_zero) begin
      y = a;
    end else if ((big.s != sml.s) && !found) begin
      y = bf16_t'(BF16_POS_ZERO);
    end else if (exp_n <= 10'sd0) begin
      y = {big.s, 15'd0};
    end else if (exp_n >= 10'sd255) begin
      y = {big.s, 8'hFF, 7'd0};
    end else begin
      y = {big.s, exp_n[7:0], mant_r[6:0]};
    end
  end

endmodule

// File: rtl/bf16_rr_arb.sv
// Combinational round-robin arbiter. Search starts one past the pointer and
// wraps; the pointer register itself lives in the caller.
module bf16_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int            idx;
  logic [IW-1:0] cand;
  logic          found;

  // First requester after the pointer wins; no grant when disabled.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/bf16_add_sched.sv
// Shares one bf16 adder between N_REQ requesters: round-robin pick, operand
// register stage, adder, result register stage with backpressure, ID tagged.
// Optional macro BF16_ADD_SCHED_STATS_EN adds saturating per-requester grant counters.
module bf16_add_sched
  import bf16_pkg::*;
#(
  parameter int N_REQ = 4
)(
  input logic             clk,
  input logic             nreset,
  bf16_add_sched_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  bf16_t             s1_a, s1_b;
  bf16_t             sel_a, sel_b, sum;
  logic [ID_W-1:0]   ptr, gnt_idx;
  logic [N_REQ-1:0]  gnt;
  logic              s1_free, s2_free, accept;

  assign s2_free = !bus.res_valid_o || bus.res_ready_i;
  assign s1_free = !s1_valid || s2_free;

  // Ready is withheld while in reset, so no handshake can complete then.
  bf16_rr_arb #(.N(N_REQ)) u_arb (
    .req     (bus.req_valid_i),
    .ptr     (ptr),
    .en      (s1_free && nreset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready_o = gnt;
  assign accept          = |gnt;

  // Operand mux for the granted requester; subtraction flips the sign of b here.
  always_comb begin
    sel_a   = bus.req_a_i[{gnt_idx, 4'b0000} +: 16];
    sel_b   = bus.req_b_i[{gnt_idx, 4'b0000} +: 16];
    sel_b.s = sel_b.s ^ bus.req_sub_i[gnt_idx];
  end

  // Stage-1 occupancy and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!nreset) begin
      s1_valid <= 1'b0;
      ptr      <= ID_W'(N_REQ - 1);
    end else if (accept) begin
      s1_valid <= 1'b1;
      ptr      <= gnt_idx;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage-1 payload.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are not reset; s1_valid qualifies them, so stale data is never observed.
    if (accept) begin
      s1_id <= gnt_idx;
      s1_a  <= sel_a;
      s1_b  <= sel_b;
    end
  end

  bf16_add u_add (
    .a (s1_a),
    .b (s1_b),
    .y (sum)
  );

  // Result stage: loads whenever it is free, holds under backpressure.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      bus.res_valid_o <= 1'b0;
      bus.res_id_o    <= '0;
      bus.res_o       <= BF16_POS_ZERO;
    end else if (s2_free) begin
      bus.res_valid_o <= s1_valid;
      if (s1_valid) begin
        bus.res_id_o <= s1_id;
        bus.res_o    <= sum;
      end
    end
  end

`ifdef BF16_ADD_SCHED_STATS_EN
  logic [15:0] grant_cnt [N_REQ];

  // Per-requester acceptance counters that stick at all-ones.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && (grant_cnt[i] != 16'hFFFF)) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
    assign bus.grant_cnt_o[16*g +: 16] = grant_cnt[g];
  end
`endif

endmodule
